// File: rtl/keccak_sponge_ctrl.sv
// Sponge sequencer for Keccak-f[1600]: absorbs message lanes, applies SHA-3 padding,
// fires one permutation per rate block, then squeezes the digest lanes.
// Optional KSC_PERF_CNT_EN adds a saturating perm_start counter (perm_count).
module keccak_sponge_ctrl #(
  parameter int          RATE_LANES = 17,
  parameter int          OUT_LANES  = 4,
  parameter logic [7:0]  DS_BYTE    = 8'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        state_clr,
  output logic        lane_we,
  output logic [4:0]  lane_idx,
  output logic [63:0] lane_data,
  output logic        perm_start,
  input  logic        perm_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  sq_idx,
  output logic        busy,
  output logic        done
`ifdef KSC_PERF_CNT_EN
  ,
  output logic [15:0] perm_count
`endif
);

  typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM, SQUEEZE, FINAL} state_t;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [4:0] SQ_LAST  = 5'(OUT_LANES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        padded_q, padded_d;     // current block carries the final pad
  logic        pad_pend_q, pad_pend_d; // full final lane ended a block; pad block follows
  logic        ds_done_q, ds_done_d;   // DS byte already written
  logic        perm_run_q, perm_run_d; // perm_start issued, waiting for perm_done
  logic        blk_end_q, blk_end_d;   // lane being written closes the block
  logic        we_d;
  logic [4:0]  idx_d;
  logic [63:0] data_d, fin_data;
  logic        short_last;

  assign in_ready  = (state_q == ABSORB);
  assign out_valid = (state_q == SQUEEZE);
  assign sq_idx    = out_valid ? cnt_q : 5'd0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINAL);
  assign short_last = (in_bytes < 4'd8);

  // Final-lane shaping: mask bytes past in_bytes, drop DS at the first free byte.
  always_comb begin
    fin_data = in_data;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) >= in_bytes) fin_data[8*k +: 8] = 8'h00;
      if (4'(k) == in_bytes) fin_data[8*k +: 8] = DS_BYTE;
    end
    if (short_last && cnt_q == LAST_IDX) fin_data[63:56] = fin_data[63:56] | 8'h80;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    padded_d   = padded_q;
    pad_pend_d = pad_pend_q;
    ds_done_d  = ds_done_q;
    perm_run_d = perm_run_q | perm_start;
    blk_end_d  = 1'b0;
    we_d       = 1'b0;
    idx_d      = lane_idx;
    data_d     = lane_data;
    state_clr  = 1'b0;
    case (state_q)
      IDLE: if (msg_start) begin
        state_clr  = 1'b1;
        cnt_d      = 5'd0;
        padded_d   = 1'b0;
        pad_pend_d = 1'b0;
        ds_done_d  = 1'b0;
        perm_run_d = 1'b0;
        state_d    = ABSORB;
      end
      ABSORB: if (in_valid) begin
        we_d   = 1'b1;
        idx_d  = cnt_q;
        data_d = in_data;
        cnt_d  = (cnt_q == LAST_IDX) ? 5'd0 : cnt_q + 5'd1;
        if (in_last) begin
          data_d    = fin_data;
          ds_done_d = short_last;
          if (cnt_q == LAST_IDX) begin
            state_d   = PERM;
            blk_end_d = 1'b1;
            if (short_last) padded_d   = 1'b1;
            else            pad_pend_d = 1'b1;
          end else begin
            state_d  = PAD;
            padded_d = 1'b1;
          end
        end else if (cnt_q == LAST_IDX) begin
          state_d   = PERM;
          blk_end_d = 1'b1;
        end
      end
      PAD: begin
        we_d      = 1'b1;
        idx_d     = cnt_q;
        data_d    = 64'd0;
        ds_done_d = 1'b1;
        if (!ds_done_q) data_d[7:0] = DS_BYTE;
        if (cnt_q == LAST_IDX) begin
          data_d[63:56] = data_d[63:56] | 8'h80;
          cnt_d     = 5'd0;
          blk_end_d = 1'b1;
          state_d   = PERM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      PERM: if (perm_run_q && perm_done) begin
        perm_run_d = 1'b0;
        cnt_d      = 5'd0;
        if (padded_q) begin
          state_d = SQUEEZE;
        end else if (pad_pend_q) begin
          pad_pend_d = 1'b0;
          padded_d   = 1'b1;
          state_d    = PAD;
        end else begin
          state_d = ABSORB;
        end
      end
      SQUEEZE: if (out_ready) begin
        if (cnt_q == SQ_LAST) begin
          cnt_d   = 5'd0;
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // perm_start trails the block's closing lane_we by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      padded_q   <= 1'b0;
      pad_pend_q <= 1'b0;
      ds_done_q  <= 1'b0;
      perm_run_q <= 1'b0;
      blk_end_q  <= 1'b0;
      lane_we    <= 1'b0;
      lane_idx   <= 5'd0;
      lane_data  <= 64'd0;
      perm_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      padded_q   <= padded_d;
      pad_pend_q <= pad_pend_d;
      ds_done_q  <= ds_done_d;
      perm_run_q <= perm_run_d;
      blk_end_q  <= blk_end_d;
      lane_we    <= we_d;
      lane_idx   <= idx_d;
      lane_data  <= data_d;
      perm_start <= blk_end_q;
    end
  end

`ifdef KSC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   perm_count <= 16'd0;
    else if (state_clr)                           perm_count <= 16'd0;
    else if (perm_start && perm_count != 16'hFFFF) perm_count <= perm_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Scoreboard bench for keccak_sponge_ctrl: byte-level SHA-3 pad model predicts every
// lane write, permutation count and squeeze index; a small responder answers perm_start.
module tb_keccak_sponge_ctrl;
  localparam int         RL = 17;
  localparam int         OL = 4;
  localparam logic [7:0] DS = 8'h06;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        msg_start = 1'b0, in_valid = 1'b0, in_last = 1'b0, perm_done = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_bytes = '0;
  logic        in_ready, state_clr, lane_we, perm_start, out_valid, busy, done;
  logic [4:0]  lane_idx, sq_idx;
  logic [63:0] lane_data;
`ifdef KSC_PERF_CNT_EN
  logic [15:0] perm_count;
`endif

  keccak_sponge_ctrl #(.RATE_LANES(RL), .OUT_LANES(OL), .DS_BYTE(DS)) dut (
    .clk(clk), .rst_n(rst_n), .msg_start(msg_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .state_clr(state_clr),
    .lane_we(lane_we), .lane_idx(lane_idx), .lane_data(lane_data), .perm_start(perm_start),
    .perm_done(perm_done), .out_valid(out_valid), .out_ready(out_ready), .sq_idx(sq_idx),
    .busy(busy), .done(done)
`ifdef KSC_PERF_CNT_EN
    , .perm_count(perm_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] idx; logic [63:0] data; } lane_t;
  lane_t      exp_q[$];
  logic [4:0] sq_q[$];
  lane_t      e_l;
  logic [4:0] e_sq;
  int checks = 0, errors = 0;
  int perm_seen = 0, done_seen = 0, pd_cnt = 0, pd_dly = 3;
  logic prev_last_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Output monitor plus round-controller stand-in (perm_done pd_dly cycles after perm_start).
  always @(negedge clk) begin
    perm_done = 1'b0;
    if (pd_cnt > 0) begin
      pd_cnt--;
      if (pd_cnt == 0) perm_done = 1'b1;
    end
    if (rst_n) begin
      if (lane_we) begin
        chk("lane_we_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e_l = exp_q.pop_front();
          chk("lane_idx", 64'(lane_idx), 64'(e_l.idx));
          chk("lane_data", lane_data, e_l.data);
        end
      end
      if (perm_start) begin
        perm_seen++;
        pd_cnt = pd_dly;
        chk("perm_start_after_last_lane", 64'(prev_last_we), 1);
      end
      prev_last_we = lane_we && (lane_idx == 5'(RL - 1));
      if (out_valid && out_ready) begin
        chk("sq_expected", 64'(sq_q.size() != 0), 1);
        if (sq_q.size() != 0) begin
          e_sq = sq_q.pop_front();
          chk("sq_idx", 64'(sq_idx), 64'(e_sq));
        end
      end
      if (done) done_seen++;
    end else begin
      prev_last_we = 1'b0;
    end
  end

  task automatic send_lane(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n = 0;
    bit hs = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    while (!hs && n < 500) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1; n++;
    end
    chk("in_ready_handshake", 64'(hs), 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Build the padded byte stream, push expected lane writes/squeeze indices, drive the message.
  task automatic start_msg(input int nl, input int fb, input bit fixed, input logic [63:0] fd,
                           input bit want_sq, output int nblk, output logic [63:0] lanes[$]);
    logic [7:0]  mq[$];
    logic [63:0] d, ln;
    for (int i = 0; i < nl; i++) begin
      d = fixed ? fd : {$urandom, $urandom};
      lanes.push_back(d);
      for (int b = 0; b < ((i == nl - 1) ? fb : 8); b++) mq.push_back(d[8*b +: 8]);
    end
    mq.push_back(DS);
    while (mq.size() % (RL * 8) != 0) mq.push_back(8'h00);
    mq[mq.size() - 1] = mq[mq.size() - 1] | 8'h80;
    nblk = mq.size() / (RL * 8);
    for (int j = 0; j < mq.size() / 8; j++) begin
      for (int b = 0; b < 8; b++) ln[8*b +: 8] = mq[8*j + b];
      exp_q.push_back({5'(j % RL), ln});
    end
    if (want_sq) for (int s = 0; s < OL; s++) sq_q.push_back(5'(s));
    msg_start = 1'b1;
    @(negedge clk);
    chk("state_clr_pulse", 64'(state_clr), 1);
    @(posedge clk); #1;
    msg_start = 1'b0;
    for (int i = 0; i < nl; i++)
      send_lane(lanes[i], i == nl - 1, (i == nl - 1) ? 4'(fb) : 4'd8);
  endtask

  task automatic run_msg(input string nm, input int nl, input int fb, input bit fixed,
                         input logic [63:0] fd, input int stall);
    int nblk, p0, d0, n, st;
    logic [63:0] lanes[$];
    p0 = perm_seen; d0 = done_seen; st = stall; n = 0;
    start_msg(nl, fb, fixed, fd, 1'b1, nblk, lanes);
    while (done_seen == d0 && n < 3000) begin
      out_ready = !(st > 0 && out_valid);
      if (!out_ready) st--;
      @(negedge clk);
      if (!out_ready && out_valid) chk("stall_sq_idx_stable", 64'(sq_idx), 0);
      if (stall > 0 && st > 0 && n > 0 && !out_valid && sq_q.size() != OL)
        chk("stall_out_valid_held", 64'(out_valid), 1);
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    chk({nm, "_done_in_time"}, 64'(n < 3000), 1);
    chk({nm, "_lanes_left"}, 64'(exp_q.size()), 0);
    chk({nm, "_perm_count"}, 64'(perm_seen - p0), 64'(nblk));
    chk({nm, "_sq_left"}, 64'(sq_q.size()), 0);
    chk({nm, "_done_once"}, 64'(done_seen - d0), 1);
`ifdef KSC_PERF_CNT_EN
    chk({nm, "_perf_cnt"}, 64'(perm_count), 64'(nblk));
`endif
    @(negedge clk);
    chk({nm, "_idle_after"}, 64'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, {in_ready, state_clr, lane_we, perm_start, out_valid, busy, done}, 0);
    chk({nm, "_lane_idx"}, 64'(lane_idx), 0);
    chk({nm, "_lane_data"}, lane_data, 0);
    chk({nm, "_sq_idx"}, 64'(sq_idx), 0);
  endtask

  initial begin
    int nblk, n, p0;
    logic [63:0] lanes[$];
    #2;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;

    run_msg("empty", 1, 0, 1'b0, 64'd0, 0);
    run_msg("abc", 1, 3, 1'b1, 64'h0000_0000_0063_6261, 0);
    run_msg("full17", 17, 8, 1'b0, 64'd0, 0);
    run_msg("b135_stall", 17, 7, 1'b0, 64'd0, 5);
    run_msg("two_blk", 20, 5, 1'b0, 64'd0, 0);

    // Abort mid-PERM: a perm_done arriving after reset must be ignored.
    pd_dly = 10; p0 = perm_seen; n = 0;
    start_msg(1, 3, 1'b1, 64'h0000_0000_0063_6261, 1'b0, nblk, lanes);
    while (perm_seen == p0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_perm_started", 64'(n < 200), 1);
    chk("abort_lanes_drained", 64'(exp_q.size()), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("abort_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    while (n < 15) begin
      @(negedge clk);
      if (n == 14) begin
        chk("abort_done_delivered", 64'(pd_cnt), 0);
        chk("abort_stays_idle", 64'(busy), 0);
        chk("abort_no_out_valid", 64'(out_valid), 0);
      end
      @(posedge clk); #1; n++;
    end
    pd_dly = 3;
    run_msg("after_abort", 2, 8, 1'b0, 64'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Sponge-level sequencer for the Keccak-f[1600] round core.
- Absorbs a byte-granular message as 64-bit lanes over a valid/ready handshake.
- Inserts SHA-3 multi-rate padding, fires one permutation per rate block, then squeezes the digest lanes out over a second valid/ready handshake.
- Sits between the message interface and the state-array/round-controller pair. It drives lane writes into the state, plus permutation start.

Parameters:
- RATE_LANES, 17, rate in 64-bit lanes (17 = SHA3-256); legal 1..21.
- OUT_LANES, 4, digest lanes squeezed; must be <= RATE_LANES (no extra squeeze permutations).
- DS_BYTE, 8'h06, domain-separation/first pad byte.

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- msg_start, in, 1, pulse: begin new message (honoured only in IDLE)
- in_valid, in, 1, message lane valid
- in_ready, out, 1, controller accepts lane
- in_data, in, 64, message lane, byte 0 = bits [7:0]
- in_last, in, 1, final lane of message
- in_bytes, in, 4, valid bytes in final lane (0..8; ignored unless in_last)
- state_clr, out, 1, pulse: zero the state array
- lane_we, out, 1, XOR lane_data into state lane lane_idx
- lane_idx, out, 5, target lane index
- lane_data, out, 64, (padded) lane to XOR
- perm_start, out, 1, pulse: run 24 rounds
- perm_done, in, 1, pulse from round controller: permutation complete
- out_valid, out, 1, digest lane sq_idx available
- out_ready, in, 1, consumer takes lane
- sq_idx, out, 5, state lane the datapath must present as digest
- busy, out, 1, high outside IDLE
- done, out, 1, one-cycle pulse after last digest lane accepted

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. On reset every output is 0, the state is IDLE and the lane counter is 0. Reset mid-operation aborts the message with no further lane_we or perm_start.
- States: IDLE, ABSORB, PAD, PERM, SQUEEZE, FINAL.
- IDLE: in_ready=0. When msg_start=1, drive state_clr=1 for that cycle, set lane counter to 0 and go to ABSORB. msg_start in any other state is ignored.
- ABSORB: in_ready=1.
  - Each accepted lane (in_valid&in_ready) produces a registered lane_we one cycle later, with lane_idx = counter and lane_data = in_data.
  - The counter increments. When it wraps from RATE_LANES-1 to 0, go to PERM (block full).
- Final lane (accepted with in_last=1):
  - Bytes >= in_bytes are masked to 0.
  - If in_bytes<8, byte[in_bytes] |= DS_BYTE; otherwise the pad begins in the next lane.
  - If the lane holding DS_BYTE is lane RATE_LANES-1, its byte 7 also gets |= 0x80, giving 0x86 when the two coincide.
  - Then go to PAD, or to PERM if the block is already complete.
  - If in_bytes==8 and that lane is RATE_LANES-1, go to PERM and then to PAD with a fresh block.
- PAD: in_ready=0. Emits one lane_we per cycle for the remaining lanes up to RATE_LANES-1:
  - the first PAD lane carries DS_BYTE in byte 0 if not yet placed;
  - lane RATE_LANES-1 carries 0x80 in byte 7;
  - all other lanes are 0.
  - Go to PERM after lane RATE_LANES-1.
- PERM: perm_start pulses on the cycle after the block's final lane_we. Wait for perm_done. perm_done received outside PERM is ignored.
  - On perm_done: go to SQUEEZE if this was the padded block; otherwise go to ABSORB with counter=0.
- SQUEEZE: out_valid=1, sq_idx = 0..OUT_LANES-1. sq_idx advances only on out_valid&out_ready. After the last lane is accepted, go to FINAL.
- FINAL: done=1 for one cycle, then IDLE.
- Empty message: msg_start followed by in_last=1 with in_bytes=0 gives lane0 = 0x06 and lane RATE_LANES-1 = 0x80<<56, i.e. one permutation.
- in_ready must deassert combinationally from the registered state, so that no lane is accepted during the PERM wait.

Optional Feature:
KSC_PERF_CNT_EN
- Defined: adds output perm_count[15:0], a count of perm_start pulses. It is cleared by reset and by state_clr and saturates at 16'hFFFF.
- Undefined: the port and the counter are absent, and there is no other behavioural change.

Test Plan:
- Empty message (RATE_LANES=17): msg_start, then in_last with in_bytes=0 -> lane0 data 64'h06; lanes 1..15 written with 0; lane16 data 64'h8000_0000_0000_0000; exactly one perm_start; after perm_done, 4 digest lanes then a done pulse.
- "abc" (in_data=64'h636261, in_bytes=3, in_last) -> lane0 data 64'h0663_6261; one permutation; sq_idx 0,1,2,3.
- 17 full lanes, the 17th with in_last and in_bytes=8 -> perm_start after lane16; after perm_done a PAD block (lane0=0x06, lane16 bit63 set); 2 permutations total.
- 16 lanes, then a final lane with in_bytes=7 -> lane16 = data | 64'h8600_0000_0000_0000 (byte 7 = 0x86 after masking), i.e. one block.
- out_ready held low 5 cycles during SQUEEZE -> sq_idx is stable and out_valid stays high; rst_n pulled low mid-PERM -> all outputs 0, IDLE, later perm_done ignored.
